line_follow_ctrl: RTL and testbench

//  Parametrised line-follower motor controller: N-sensor IPS array plus IR beacon in, direction codes and PWM enables
//  for left/right drivers out. Successor to the fixed 2+1-sensor controller: configurable sensor count, PWM resolution
//  and duties, steer timeout and beacon hold. Sits between sensor inputs and the H-bridge pins at top level.

---
 rtl/line_follow_pkg.sv | 17 +
 rtl/line_follow_ctrl_pwm.sv | 33 +++
 rtl/line_follow_ctrl.sv | 175 +++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/line_follow_pkg.sv
// Shared types and constants for the line-follower controller.
// State encodings are visible on state_o, so their values are fixed.
package line_follow_pkg;

  typedef enum logic [2:0] {
    StInit    = 3'd0,
    StFollow  = 3'd1,
    StSteer   = 3'd2,
    StBeacon  = 3'd3,
    StDeadend = 3'd4
  } state_e;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;

endpackage

// File: rtl/line_follow_ctrl_pwm.sv
// Shared free-running PWM counter with one registered comparator per motor channel.
// A duty of 2**PWM_W (the widest value on i_duty_*) keeps the enable permanently on.
module pwm_gen #(
  parameter int unsigned PWM_W = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [PWM_W:0] i_duty_l,
  input  logic [PWM_W:0] i_duty_r,
  output logic           o_en_l,
  output logic           o_en_r
);

  logic [PWM_W-1:0] r_cnt;
  logic             r_en_l;
  logic             r_en_r;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_en_l <= 1'b0;
      r_en_r <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + PWM_W'(1);
      r_en_l <= ({1'b0, r_cnt} < i_duty_l);
      r_en_r <= ({1'b0, r_cnt} < i_duty_r);
    end
  end

  assign o_en_l = r_en_l;
  assign o_en_r = r_en_r;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follower motor controller: IPS sensor array and IR beacon in, H-bridge direction
// codes and PWM enables out. Direction and duty are registered together with the state.
module line_follow_ctrl
  import line_follow_pkg::*;
#(
  parameter int unsigned N_IPS       = 3,
  parameter int unsigned PWM_W       = 8,
  parameter int unsigned DUTY_FWD    = 64,
  parameter int unsigned DUTY_TURN   = 192,
  parameter int unsigned LOST_TO     = 1000,
  parameter int unsigned BEACON_HOLD = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IPS-1:0] ips,
  input  logic [1:0]       ir,
  output logic [1:0]       dir_l,
  output logic [1:0]       dir_r,
  output logic             en_l,
  output logic             en_r,
  output logic [2:0]       state_o,
  output logic             beacon_p
);

  localparam int unsigned C         = N_IPS / 2;
  localparam int unsigned PopW      = $clog2(N_IPS + 1);
  localparam int unsigned SteerW    = (LOST_TO > 1) ? $clog2(LOST_TO) : 1;
  localparam int unsigned HoldW     = (BEACON_HOLD > 1) ? $clog2(BEACON_HOLD) : 1;
  localparam int unsigned FullScale = 2 ** PWM_W;

  localparam logic [PWM_W:0] DutyFwd =
    (PWM_W + 1)'((DUTY_FWD >= FullScale) ? FullScale : DUTY_FWD);
  localparam logic [PWM_W:0] DutyTurn =
    (PWM_W + 1)'((DUTY_TURN >= FullScale) ? FullScale : DUTY_TURN);
  localparam logic [SteerW-1:0] SteerLast = SteerW'(LOST_TO - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(BEACON_HOLD - 1);

  state_e            r_state;
  logic [1:0]        r_dir_l;
  logic [1:0]        r_dir_r;
  logic [PWM_W:0]    r_duty;
  logic [SteerW-1:0] r_steer_cnt;
  logic [HoldW-1:0]  r_hold_cnt;
  logic              r_beacon_p;

  state_e            w_next;
  logic [1:0]        w_dir_l;
  logic [1:0]        w_dir_r;
  logic [PWM_W:0]    w_duty;
  logic [SteerW-1:0] w_steer_cnt;
  logic [HoldW-1:0]  w_hold_cnt;
  logic              w_beacon_p;
  logic [PopW-1:0]   w_l;
  logic [PopW-1:0]   w_r;
  logic              w_bal;
  logic              w_ir;
  logic              w_lost;

  // Sensors left of centre occupy ips[N_IPS-1:C+1], right of centre ips[C-1:0].
  always_comb begin
    w_l = '0;
    w_r = '0;
    for (int i = 0; i < C; i++) begin
      w_r = w_r + PopW'(ips[i]);
      w_l = w_l + PopW'(ips[C+1+i]);
    end
  end

  assign w_bal  = ips[C] && (w_l == w_r);
  assign w_ir   = (ir != 2'b00);
  assign w_lost = (ips == '0);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StInit: w_next = StFollow;
      StFollow: begin
        if (w_ir)        w_next = StBeacon;
        else if (w_lost) w_next = StDeadend;
        else if (!w_bal) w_next = StSteer;
      end
      StSteer: begin
        if (w_ir)                          w_next = StBeacon;
        else if (w_lost)                   w_next = StDeadend;
        else if (w_bal)                    w_next = StFollow;
        else if (r_steer_cnt == SteerLast) w_next = StDeadend;
      end
      StBeacon: begin
        if ((r_hold_cnt >= HoldLast) && !w_ir) w_next = StFollow;
      end
      StDeadend: begin
        if (w_ir)         w_next = StBeacon;
        else if (!w_lost) w_next = StFollow;
      end
      default: w_next = StFollow;
    endcase
  end

  // Outputs describe the state being entered, so they line up with state_o.
  always_comb begin
    w_dir_l = DIR_STOP;
    w_dir_r = DIR_STOP;
    w_duty  = '0;
    if (w_next == StFollow) begin
      w_dir_l = DIR_FWD;
      w_dir_r = DIR_FWD;
      w_duty  = DutyFwd;
    end else if (w_next == StSteer) begin
      if (w_l > w_r) begin
        w_dir_l = DIR_REV;
        w_dir_r = DIR_FWD;
        w_duty  = DutyTurn;
      end else if (w_r > w_l) begin
        w_dir_l = DIR_FWD;
        w_dir_r = DIR_REV;
        w_duty  = DutyTurn;
      end else begin
        w_dir_l = DIR_FWD;
        w_dir_r = DIR_FWD;
        w_duty  = DutyFwd;
      end
    end
  end

  always_comb begin
    w_steer_cnt = '0;
    w_hold_cnt  = '0;
    w_beacon_p  = (w_next == StBeacon) && (r_state != StBeacon);
    if ((r_state == StSteer) && (w_next == StSteer) && (r_steer_cnt < SteerLast)) begin
      w_steer_cnt = r_steer_cnt + SteerW'(1);
    end else if ((r_state == StSteer) && (w_next == StSteer)) begin
      w_steer_cnt = r_steer_cnt;
    end
    if ((r_state == StBeacon) && (w_next == StBeacon)) begin
      w_hold_cnt = (r_hold_cnt < HoldLast) ? r_hold_cnt + HoldW'(1) : r_hold_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StInit;
      r_dir_l     <= DIR_STOP;
      r_dir_r     <= DIR_STOP;
      r_duty      <= '0;
      r_steer_cnt <= '0;
      r_hold_cnt  <= '0;
      r_beacon_p  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_dir_l     <= w_dir_l;
      r_dir_r     <= w_dir_r;
      r_duty      <= w_duty;
      r_steer_cnt <= w_steer_cnt;
      r_hold_cnt  <= w_hold_cnt;
      r_beacon_p  <= w_beacon_p;
    end
  end

  pwm_gen #(
    .PWM_W(PWM_W)
  ) u_pwm (
    .i_clk   (clk),
    .i_reset (reset),
    .i_duty_l(r_duty),
    .i_duty_r(r_duty),
    .o_en_l  (en_l),
    .o_en_r  (en_r)
  );

  assign dir_l    = r_dir_l;
  assign dir_r    = r_dir_r;
  assign state_o  = r_state;
  assign beacon_p = r_beacon_p;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl: directed scenarios then random stimulus, every cycle
// compared against a cycle-level behavioural model of the controller.
module tb_line_follow_ctrl;

  localparam int N_IPS = 3, PWM_W = 4, DUTY_FWD = 4, DUTY_TURN = 12;
  localparam int LOST_TO = 8, BEACON_HOLD = 4, FULL = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ips = 3'b010;
  logic [1:0] ir = 2'b00;
  logic [1:0] dir_l, dir_r;
  logic       en_l, en_r, beacon_p;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: controller mode, registered outputs, pwm counter and duty.
  int m_state = 0, m_dl = 0, m_dr = 0, m_en = 0, m_bp = 0;
  int m_cnt = 0, m_duty = 0, m_steer = 0, m_hold = 0;

  line_follow_ctrl #(
    .N_IPS(N_IPS), .PWM_W(PWM_W), .DUTY_FWD(DUTY_FWD), .DUTY_TURN(DUTY_TURN),
    .LOST_TO(LOST_TO), .BEACON_HOLD(BEACON_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .ips(ips), .ir(ir), .dir_l(dir_l), .dir_r(dir_r),
    .en_l(en_l), .en_r(en_r), .state_o(state_o), .beacon_p(beacon_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input logic [2:0] p, input logic [1:0] r, input logic rst);
    int l, rr, nxt;
    bit bal, beac, lost;
    if (rst) begin
      m_state = 0; m_dl = 0; m_dr = 0; m_en = 0; m_bp = 0;
      m_cnt = 0; m_duty = 0; m_steer = 0; m_hold = 0;
      return;
    end
    m_en  = (m_cnt < min_i(m_duty, FULL)) ? 1 : 0;
    m_cnt = (m_cnt + 1) % FULL;
    l    = int'(p[2]);
    rr   = int'(p[0]);
    bal  = p[1] && (l == rr);
    beac = (r != 0);
    lost = (p == 0);
    case (m_state)
      0: nxt = 1;
      1: nxt = beac ? 3 : lost ? 4 : !bal ? 2 : 1;
      2: nxt = beac ? 3 : lost ? 4 : bal ? 1 : (m_steer == LOST_TO - 1) ? 4 : 2;
      3: nxt = (m_hold >= BEACON_HOLD - 1 && !beac) ? 1 : 3;
      4: nxt = beac ? 3 : !lost ? 1 : 4;
      default: nxt = 1;
    endcase
    m_steer = (m_state == 2 && nxt == 2) ? min_i(m_steer + 1, LOST_TO - 1) : 0;
    m_hold  = (m_state == 3 && nxt == 3) ? min_i(m_hold + 1, BEACON_HOLD - 1) : 0;
    m_bp    = (nxt == 3 && m_state != 3) ? 1 : 0;
    m_dl = 0; m_dr = 0; m_duty = 0;
    if (nxt == 1) begin
      m_dl = 1; m_dr = 1; m_duty = DUTY_FWD;
    end else if (nxt == 2) begin
      if (l > rr) begin
        m_dl = 2; m_dr = 1; m_duty = DUTY_TURN;
      end else if (rr > l) begin
        m_dl = 1; m_dr = 2; m_duty = DUTY_TURN;
      end else begin
        m_dl = 1; m_dr = 1; m_duty = DUTY_FWD;
      end
    end
    m_state = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_step(ips, ir, reset);
    #1;
    check("state", state_o, m_state);
    check("dir_l", dir_l, m_dl);
    check("dir_r", dir_r, m_dr);
    check("en_l", en_l, m_en);
    check("en_r", en_r, m_en);
    check("beacon_p", beacon_p, m_bp);
  endtask

  initial begin
    int hi, n, bp;
    // 1: reset, release, straight following at 4/16 duty
    reset = 1'b1;
    repeat (3) step();
    check("rst_state", state_o, 0);
    check("rst_en", en_l, 0);
    reset = 1'b0;
    ips = 3'b010;
    step();
    check("follow_entry", state_o, 1);
    check("follow_dir", {dir_l, dir_r}, 4'b0101);
    repeat (2) step();
    hi = 0;
    repeat (16) begin
      step();
      hi += int'(en_l);
    end
    check("fwd_duty", hi, DUTY_FWD);

    // 2: pivot left, back to follow
    ips = 3'b100;
    step();
    check("steer_entry", state_o, 2);
    check("steer_dir", {dir_l, dir_r}, 4'b1001);
    repeat (3) step();
    ips = 3'b010;
    step();
    check("steer_exit", state_o, 1);

    // 3: steer timeout after exactly LOST_TO steer cycles
    ips = 3'b001;
    n = 0;
    repeat (9) begin
      step();
      if (state_o == 3'd2) n++;
    end
    check("steer_len", n, LOST_TO);
    check("deadend", state_o, 4);
    check("deadend_dir", {dir_l, dir_r}, 4'b0000);
    ips = 3'b010;
    step();
    check("deadend_exit", state_o, 1);

    // 4: beacon beats deadend, minimum hold
    ips = 3'b000;
    ir = 2'b01;
    step();
    check("beacon_entry", state_o, 3);
    check("beacon_pulse", beacon_p, 1);
    ir = 2'b00;
    ips = 3'b010;
    n = 1;
    bp = 0;
    repeat (8) begin
      step();
      if (state_o == 3'd3) n++;
      bp += int'(beacon_p);
    end
    check("beacon_len", n, BEACON_HOLD);
    check("beacon_no_repulse", bp, 0);

    // 5: ir held past hold keeps beacon
    ir = 2'b01;
    bp = 0;
    repeat (9) begin
      step();
      bp += int'(beacon_p);
    end
    check("beacon_held", state_o, 3);
    check("beacon_one_pulse", bp, 1);
    ir = 2'b00;
    step();
    check("beacon_release", state_o, 1);

    // 6: reset in the middle of steering, then a full timeout
    ips = 3'b100;
    repeat (6) step();
    check("steer_before_rst", state_o, 2);
    reset = 1'b1;
    step();
    check("midrst_state", state_o, 0);
    check("midrst_dir", {dir_l, dir_r}, 4'b0000);
    reset = 1'b0;
    step();
    n = 0;
    repeat (9) begin
      step();
      if (state_o == 3'd2) n++;
    end
    check("restart_steer_len", n, LOST_TO);
    check("restart_deadend", state_o, 4);

    // Random stimulus; inputs dwell so timeouts and holds get exercised.
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) ips = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 11) == 0) ir = 2'($urandom_range(1, 3));
      else if ($urandom_range(0, 2) == 0) ir = 2'b00;
      reset = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
